axi_w_order_ctrl: RTL and testbench
===================================

Name: axi_w_order_ctrl

Overview:
Write-data channel sequencer for the 2-master AXI interconnect. It sits beside the AW arbiter and records, in AW-grant order, which master won each write burst and its burst length. It then routes that master's W beats to the shared slave-side W channel, one burst at a time, and regenerates WLAST from a beat counter. It also flags any mismatch between the master's WLAST and the granted length.

Parameters:
DEPTH, 4, number of outstanding AW grants recorded (power of 2, >=2)
DATA_W, 32, W data width (`AXI_DATA_BITS)
LEN_W, 4, burst length width (`AXI_LEN_BITS); beats = len+1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
aw_fire  input  1  slave-side AW handshake this cycle (O_Valid & OB_Ready)
aw_mst  input  1  granted master for that AW: 0 = M0, 1 = M1
aw_len  input  LEN_W  granted burst length
aw_block  output  1  order FIFO full; AW arbiter must hold OB_Ready low
m0_wdata / m1_wdata  input  DATA_W  master W data
m0_wstrb / m1_wstrb  input  DATA_W/8  master W strobes
m0_wlast / m1_wlast  input  1  master WLAST
m0_wvalid / m1_wvalid  input  1  master WVALID
m0_wready / m1_wready  output  1  WREADY back to each master
s_wdata  output  DATA_W  slave-side W data
s_wstrb  output  DATA_W/8  slave-side strobes
s_wlast  output  1  regenerated WLAST
s_wvalid  output  1  slave-side WVALID
s_wready  input  1  slave WREADY
len_err  output  1  one-cycle pulse on WLAST/length mismatch

Behaviour:
- Reset (async, rst=1): FIFO empty, rd/wr pointers 0, beat_cnt 0, state IDLE.
  - Outputs during reset: aw_block 0, all wready 0, s_wvalid 0, s_wlast 0, s_wdata 0, s_wstrb 0, len_err 0.
- Order FIFO:
  - Entries are {mst, len}, DEPTH deep, with pointers one bit wider than log2(DEPTH) for full/empty detection.
  - Push on aw_fire. aw_block = full, purely from registered state.
  - aw_fire while full is illegal and is ignored: no push, no pointer change.
  - A simultaneous push and pop at any occupancy is legal; the count is unchanged.
- State machine:
  - IDLE: FIFO empty. No routing, all wready 0.
  - IDLE -> BURST when the FIFO is non-empty (registered).
  - A push at cycle N allows the first W beat to be routed at cycle N+1, never at N.
  - BURST: head.mst selects the source master.
    - s_wvalid = sel_wvalid.
    - sel_wready = s_wready.
    - The unselected master's wready is 0.
    - s_wdata and s_wstrb are muxed from the selected master; they are 0 in IDLE.
    - s_wlast = (beat_cnt == head.len).
    - Beat handshake = s_wvalid & s_wready.
    - On a handshake with beat_cnt != head.len: beat_cnt++.
    - On a handshake with beat_cnt == head.len: pop, beat_cnt <= 0.
    - After the pop, stay in BURST if the FIFO is still non-empty (back-to-back bursts with no bubble), otherwise go to IDLE.
- Length authority: the count from aw_len defines the burst end, not the master's WLAST.
  - len_err pulses on a handshake where the selected master's wlast != s_wlast.
  - The burst still ends on the count.
- Combinational paths: wready to master depends combinationally on s_wready (zero-latency pass-through). There is no W buffering in this block.
- Counter width: beat_cnt is LEN_W bits. len = 2^LEN_W - 1 (16 beats at the default) must terminate correctly, with no wrap before compare.
- Reset mid-burst: all state is discarded immediately. After release the block is in IDLE with the FIFO empty; remaining beats of the aborted burst are not routed.
- len = 0: single beat; s_wlast = 1 on the first beat.

Decomposition:
- Shared package axi_pkg: `AXI_LEN_BITS, `AXI_DATA_BITS, `AXI_STRB_BITS; a typedef w_order_t {logic mst; logic [LEN_W-1:0] len;}; state enum {W_IDLE, W_BURST}.
- One sub-module, sync_fifo_ptr (generic DEPTH x WIDTH register FIFO with full/empty flags), instantiated for the order queue.
- Counter, FSM and mux stay in the top.

Test Plan:
- Single burst: aw_fire with mst=0, len=3; M0 drives 4 beats 0xA0..0xA3 with wlast on the 4th; s_wready=1. Required: s_wdata carries A0..A3 in cycles N+1..N+4, s_wlast only with A3, m1_wready=0 throughout, len_err=0, FIFO empty afterwards.
- Ordering: AW grants M1 len=1, then M0 len=0, in consecutive cycles; both masters hold data valid. Required: two M1 beats first, then one M0 beat in the next cycle with no bubble. m0_wready=0 until the M1 pop.
- Full/backpressure: 4 grants with no W activity. Required: aw_block=1 after the 4th push. A 5th aw_fire is ignored. Completing one 1-beat burst drops aw_block the following cycle.
- Stall: len=2 with s_wready toggling 1,0,1,0,1. Required: beat_cnt advances only on handshakes, s_wdata is held stable while stalled, and 3 beats are transferred.
- Length error: len=1, master asserts wlast on beat 0. Required: len_err pulses for 1 cycle, s_wlast=0 on beat 0, and the burst ends after beat 1.
- Max length and reset: len=15 completes 16 beats with s_wlast on the 16th. In a second run, rst asserted after 5 beats leaves all outputs 0, aw_block=0 and the FIFO empty.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI widths, W-order entry type and W sequencer state encoding.
// Imported by the write-data ordering block and its bench.
package axi_pkg;

   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

   typedef struct packed {
      logic                    mst;
      logic [AXI_LEN_BITS-1:0] len;
   } w_order_t;

   typedef enum logic {
      W_IDLE  = 1'b0,
      W_BURST = 1'b1
   } w_state_e;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Generic register FIFO with extra-bit pointers for full/empty.
// Pushes while full and pops while empty are dropped.
module sync_fifo_ptr #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_empty = (r_wr == r_rd);
   assign o_count = r_wr - r_rd;
   assign o_dout  = r_mem[r_rd[AW-1:0]];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Storage write on an accepted push
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
   end

   // Pointer update; push and pop may coincide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
      end
   end

endmodule

// File: rtl/axi_w_order_ctrl.sv
// W-channel sequencer: routes W beats in AW-grant order and
// regenerates WLAST from the granted length.
module axi_w_order_ctrl
   import axi_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = AXI_DATA_BITS,
   parameter int LEN_W  = AXI_LEN_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                aw_fire,
   input  logic                aw_mst,
   input  logic [LEN_W-1:0]    aw_len,
   output logic                aw_block,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   input  logic                m0_wlast,
   input  logic                m0_wvalid,
   output logic                m0_wready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   output logic                s_wvalid,
   input  logic                s_wready,
   output logic                len_err
);

   localparam int PW = $clog2(DEPTH) + 1;

   w_state_e         r_state;
   w_state_e         w_state_nx;
   logic [LEN_W-1:0] r_beat;
   logic [LEN_W:0]   w_head;
   logic [PW-1:0]    w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_burst;
   logic             w_sel;
   logic [LEN_W-1:0] w_hlen;
   logic             w_at_end;
   logic             w_sel_wlast;
   logic             w_hs;

   assign w_push   = aw_fire & ~w_full;
   assign aw_block = w_full;

   sync_fifo_ptr #(
      .DEPTH (DEPTH),
      .WIDTH (LEN_W + 1)
   ) u_order_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   ({aw_mst, aw_len}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_burst     = (r_state == W_BURST);
   assign w_sel       = w_head[LEN_W];
   assign w_hlen      = w_head[LEN_W-1:0];
   assign w_at_end    = (r_beat == w_hlen);
   assign w_sel_wlast = w_sel ? m1_wlast : m0_wlast;
   assign w_hs        = s_wvalid & s_wready;
   assign w_pop       = w_hs & w_at_end;
   assign len_err     = w_hs & (w_sel_wlast != w_at_end);

   // Steer the head master onto the slave W channel
   always_comb begin
      s_wvalid  = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wlast   = 1'b0;
      m0_wready = 1'b0;
      m1_wready = 1'b0;
      if (w_burst) begin
         s_wlast = w_at_end;
         if (w_sel) begin
            s_wvalid  = m1_wvalid;
            s_wdata   = m1_wdata;
            s_wstrb   = m1_wstrb;
            m1_wready = s_wready;
         end else begin
            s_wvalid  = m0_wvalid;
            s_wdata   = m0_wdata;
            s_wstrb   = m0_wstrb;
            m0_wready = s_wready;
         end
      end
   end

   // Beat counter: clears on the last beat of a burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat <= '0;
      end else if (w_hs) begin
         r_beat <= w_at_end ? '0 : r_beat + 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= W_IDLE;
      else     r_state <= w_state_nx;
   end

   // Next state: BURST whenever the order queue is non-empty next cycle
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         W_IDLE: begin
            if (w_push | ~w_empty) w_state_nx = W_BURST;
         end
         W_BURST: begin
            if (w_pop && (w_count == PW'(1)) && !w_push)
               w_state_nx = W_IDLE;
         end
         default: w_state_nx = W_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_w_order_ctrl.sv
// Self-checking bench for axi_w_order_ctrl: vector table of bursts
// plus ordering, full, and reset sequences, with a beat scoreboard.
module tb_axi_w_order_ctrl;
   import axi_pkg::*;

   localparam int DW = 32;
   localparam int SW = 4;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          aw_fire = 1'b0;
   logic          aw_mst = 1'b0;
   logic [LW-1:0] aw_len = '0;
   logic          aw_block;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic [SW-1:0] m0_wstrb = '0, m1_wstrb = '0;
   logic          m0_wlast = 1'b0, m1_wlast = 1'b0;
   logic          m0_wvalid = 1'b0, m1_wvalid = 1'b0;
   logic          m0_wready, m1_wready;
   logic [DW-1:0] s_wdata;
   logic [SW-1:0] s_wstrb;
   logic          s_wlast, s_wvalid;
   logic          s_wready = 1'b1;
   logic          len_err;

   always #5 clk = ~clk;

   axi_w_order_ctrl #(.DEPTH(4), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst),
      .aw_fire(aw_fire), .aw_mst(aw_mst), .aw_len(aw_len),
      .aw_block(aw_block),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
      .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .len_err(len_err)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic          last;
      logic          err;
      logic          mst;
   } exp_t;

   typedef struct {
      logic        mst;
      int          len;
      logic [15:0] mask;
      logic [31:0] base;
      logic        stall;
      int          exp_beats;
      int          exp_errs;
   } vec_t;

   beat_t mq0[$];
   beat_t mq1[$];
   exp_t  sbq[$];
   exp_t  me;
   vec_t  vt[7];

   int   checks = 0;
   int   errors = 0;
   int   beats_seen = 0;
   int   errs_seen = 0;
   int   stalls_seen = 0;
   logic hs0_q = 1'b0;
   logic hs1_q = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Queue master beats and the slave-side beats they must become
   task automatic load_burst(input logic mst, input int len,
                             input logic [15:0] mask,
                             input logic [31:0] base);
      for (int b = 0; b <= len; b++) begin
         beat_t m;
         exp_t  e;
         logic [31:0] d;
         d      = base + 32'(b);
         m.data = d;
         m.strb = d[3:0] ^ 4'h9;
         m.last = mask[b];
         e.data = m.data;
         e.strb = m.strb;
         e.last = (b == len);
         e.err  = (m.last != e.last);
         e.mst  = mst;
         if (mst) mq1.push_back(m);
         else     mq0.push_back(m);
         sbq.push_back(e);
      end
   endtask

   task automatic issue_aw(input logic m, input int l);
      @(posedge clk); #1;
      aw_fire = 1'b1;
      aw_mst  = m;
      aw_len  = LW'(l);
      @(posedge clk); #1;
      aw_fire = 1'b0;
   endtask

   task automatic drain(input logic stall, input int budget);
      int   n;
      logic tog;
      n   = 0;
      tog = 1'b0;
      while (sbq.size() > 0 && n < budget) begin
         @(posedge clk); #1;
         if (stall) begin
            tog      = ~tog;
            s_wready = tog;
         end
         n++;
      end
      s_wready = 1'b1;
      chk("drain_left", 64'(sbq.size()), 0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      beats_seen  = 0;
      errs_seen   = 0;
      stalls_seen = 0;
      load_burst(v.mst, v.len, v.mask, v.base);
      issue_aw(v.mst, v.len);
      drain(v.stall, 100);
      chk("vec_beats", 64'(beats_seen), 64'(v.exp_beats));
      chk("vec_errs", 64'(errs_seen), 64'(v.exp_errs));
      chk("vec_stalled", 64'(stalls_seen > 0), 64'(v.stall));
      chk("vec_fifo_empty", 64'(dut.w_empty), 1);
      chk("vec_aw_block", 64'(aw_block), 0);
   endtask

   // Master models: retire accepted beats, present the next one
   always begin
      @(posedge clk); #1;
      if (hs0_q && mq0.size() > 0) mq0.delete(0);
      if (hs1_q && mq1.size() > 0) mq1.delete(0);
      m0_wvalid = (mq0.size() > 0);
      m1_wvalid = (mq1.size() > 0);
      if (mq0.size() > 0) begin
         m0_wdata = mq0[0].data;
         m0_wstrb = mq0[0].strb;
         m0_wlast = mq0[0].last;
      end else begin
         m0_wdata = '0;
         m0_wstrb = '0;
         m0_wlast = 1'b0;
      end
      if (mq1.size() > 0) begin
         m1_wdata = mq1[0].data;
         m1_wstrb = mq1[0].strb;
         m1_wlast = mq1[0].last;
      end else begin
         m1_wdata = '0;
         m1_wstrb = '0;
         m1_wlast = 1'b0;
      end
   end

   // Slave-side monitor and scoreboard compare
   always @(negedge clk) begin
      hs0_q = !rst && m0_wvalid && m0_wready;
      hs1_q = !rst && m1_wvalid && m1_wready;
      if (!rst && s_wvalid) begin
         if (s_wready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=%0h required=none",
                        s_wdata);
            end else begin
               me = sbq.pop_front();
               chk("s_wdata", 64'(s_wdata), 64'(me.data));
               chk("s_wstrb", 64'(s_wstrb), 64'(me.strb));
               chk("s_wlast", 64'(s_wlast), 64'(me.last));
               chk("len_err", 64'(len_err), 64'(me.err));
               chk("other_wready",
                   64'(me.mst ? m0_wready : m1_wready), 0);
               beats_seen++;
               if (len_err) errs_seen++;
            end
         end else begin
            stalls_seen++;
            if (sbq.size() > 0)
               chk("stall_hold", 64'(s_wdata), 64'(sbq[0].data));
            chk("stall_no_err", 64'(len_err), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int n;
      vt[0] = '{1'b0,  3, 16'h0008, 32'h0A0, 1'b0,  4, 0};
      vt[1] = '{1'b1,  0, 16'h0001, 32'h0B0, 1'b0,  1, 0};
      vt[2] = '{1'b1, 15, 16'h8000, 32'h100, 1'b0, 16, 0};
      vt[3] = '{1'b0,  1, 16'h0003, 32'h0C0, 1'b0,  2, 1};
      vt[4] = '{1'b0,  1, 16'h0001, 32'h0D0, 1'b0,  2, 2};
      vt[5] = '{1'b0,  2, 16'h0004, 32'h0E0, 1'b1,  3, 0};
      vt[6] = '{1'b1,  2, 16'h0000, 32'h0F0, 1'b0,  3, 1};

      repeat (2) @(negedge clk);
      chk("rst_outs", 64'({aw_block, s_wvalid, s_wlast, s_wdata,
                          s_wstrb, m0_wready, m1_wready, len_err}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) run_vec(vt[i]);

      // Ordering: M1 len1 then M0 len0 on consecutive grants
      beats_seen = 0;
      load_burst(1'b1, 1, 16'h0002, 32'h10);
      load_burst(1'b0, 0, 16'h0001, 32'h20);
      @(posedge clk); #1;
      aw_fire = 1'b1; aw_mst = 1'b1; aw_len = 4'd1;
      @(negedge clk);
      chk("lat_push_cycle", 64'(s_wvalid), 0);
      chk("ord_m0rdy_n", 64'(m0_wready), 0);
      @(posedge clk); #1;
      aw_mst = 1'b0; aw_len = 4'd0;
      @(negedge clk);
      chk("lat_next_cycle", 64'(s_wvalid), 1);
      chk("ord_m1rdy", 64'(m1_wready), 1);
      chk("ord_m0rdy_1", 64'(m0_wready), 0);
      @(posedge clk); #1;
      aw_fire = 1'b0;
      @(negedge clk);
      chk("ord_m0rdy_2", 64'(m0_wready), 0);
      @(negedge clk);
      chk("no_bubble", 64'(s_wvalid), 1);
      chk("ord_m0rdy_3", 64'(m0_wready), 1);
      drain(1'b0, 20);
      chk("ord_beats", 64'(beats_seen), 3);

      // Full: four grants without data, fifth ignored
      for (int i = 0; i < 4; i++) begin
         issue_aw(1'b0, 0);
         chk("aw_block_fill", 64'(aw_block), 64'(i == 3));
      end
      issue_aw(1'b1, 5);
      chk("aw_block_hold", 64'(aw_block), 1);
      chk("full_count", 64'(dut.w_count), 4);
      load_burst(1'b0, 0, 16'h0001, 32'h30);
      n = 0;
      @(negedge clk);
      while (!(s_wvalid && s_wready) && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("pop_seen", 64'(n < 10), 1);
      chk("block_at_pop", 64'(aw_block), 1);
      @(negedge clk);
      chk("block_drop", 64'(aw_block), 0);
      for (int i = 0; i < 3; i++) load_burst(1'b0, 0, 16'h0001, 32'h40 + 32'(i));
      drain(1'b0, 30);
      chk("full_fifo_empty", 64'(dut.w_empty), 1);

      // Reset after five beats of a 16-beat burst
      beats_seen = 0;
      load_burst(1'b0, 15, 16'h8000, 32'h200);
      issue_aw(1'b0, 15);
      n = 0;
      while (beats_seen < 5 && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      rst = 1'b1;
      sbq.delete();
      @(negedge clk);
      chk("rst_beats", 64'(beats_seen), 5);
      chk("rst_mid_outs", 64'({aw_block, s_wvalid, s_wlast, s_wdata,
                              s_wstrb, m0_wready, m1_wready, len_err}), 0);
      chk("rst_fifo_empty", 64'(dut.w_empty), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_route", 64'({s_wvalid, m0_wready}), 0);
      end
      @(posedge clk); #1;
      mq0.delete();
      mq1.delete();
      repeat (2) @(posedge clk);
      #1;
      run_vec(vt[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
